alu_issue_seq: RTL and testbench

//  Issue/collect sequencer that drives the combinational 16-bit ALU: accepts an op request
//  (ALUOp + funct + two operands) over valid/ready, decodes to the 3-bit ALU_ctrl code,

---
 rtl/alu_issue_seq_if.sv | 27 ++
 rtl/alu_issue_seq.sv | 126 ++++++++++++
 tb/tb_alu_issue_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_seq_if.sv
// Request/response handshake bundle between the issuing control and alu_issue_seq.
// Master drives requests and consumes responses; slave is the sequencer side.
interface alu_issue_seq_if #(
   parameter int W = 16
);
   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_aluop;
   logic [2:0]   req_funct;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_zero;
   logic         rsp_err;

   modport master (
      output req_valid, req_aluop, req_funct, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
   );

   modport slave (
      input  req_valid, req_aluop, req_funct, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
   );
endinterface

// File: rtl/alu_issue_seq.sv
// Issue/collect sequencer for the combinational 16-bit ALU; one op in flight.
// Optional macro ALU_SLT_EN enables the slt (funct 100) decode.
module alu_issue_seq #(
   parameter int inst_SIZE = 16,
   parameter int MUL_LAT   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_issue_seq_if.slave       bus,
   output logic [2:0]           ALU_ctrl,
   output logic [inst_SIZE-1:0] in0,
   output logic [inst_SIZE-1:0] in1,
   input  logic [inst_SIZE-1:0] ALU_output,
   input  logic                 zero
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e               state_q, state_d;
   logic [2:0]           ctrl_q, ctrl_d;
   logic [inst_SIZE-1:0] in0_q, in0_d;
   logic [inst_SIZE-1:0] in1_q, in1_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [inst_SIZE-1:0] data_q, data_d;
   logic                 zero_q, zero_d;
   logic                 err_q, err_d;
   logic [2:0]           dec_ctrl;
   logic                 dec_ill;

   always_comb begin
      dec_ctrl = 3'b000;
      dec_ill  = 1'b0;
      case (bus.req_aluop)
         2'b00: dec_ctrl = 3'b000;
         2'b01: dec_ctrl = 3'b001;
         2'b11: dec_ctrl = 3'b011;
         default: begin
            case (bus.req_funct)
               3'b110, 3'b111: dec_ill = 1'b1;
`ifdef ALU_SLT_EN
               3'b100: dec_ctrl = 3'b100;
`else
               3'b100: dec_ill = 1'b1;
`endif
               default: dec_ctrl = bus.req_funct;
            endcase
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      in0_d   = in0_q;
      in1_d   = in1_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      zero_d  = zero_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (dec_ill) begin
                  // ALU inputs untouched so the datapath sees no spurious op
                  data_d  = '0;
                  zero_d  = 1'b0;
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  in0_d   = bus.req_a;
                  in1_d   = bus.req_b;
                  ctrl_d  = dec_ctrl;
                  cnt_d   = (dec_ctrl == 3'b101) ? 4'(MUL_LAT - 1) : 4'd0;
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               data_d  = ALU_output;
               zero_d  = zero;
               err_d   = 1'b0;
               state_d = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ctrl_q  <= 3'b000;
         in0_q   <= '0;
         in1_q   <= '0;
         cnt_q   <= 4'd0;
         data_q  <= '0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         in0_q   <= in0_d;
         in1_q   <= in1_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_data  = data_q;
   assign bus.rsp_zero  = zero_q;
   assign bus.rsp_err   = err_q;
   assign ALU_ctrl      = ctrl_q;
   assign in0           = in0_q;
   assign in1           = in1_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural ALU on the datapath side.
// Build with +define+ALU_SLT_EN to cover the slt decode.
module tb_alu_issue_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  ALU_ctrl;
   logic [15:0] in0, in1, ALU_output;
   logic        zero;
   int          checks = 0;
   int          failures = 0;

   alu_issue_seq_if #(.W(16)) bus ();

   alu_issue_seq #(.inst_SIZE(16), .MUL_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .ALU_ctrl(ALU_ctrl), .in0(in0), .in1(in1),
      .ALU_output(ALU_output), .zero(zero)
   );

   always #5 clk = ~clk;

   always_comb begin
      ALU_output = 16'h0000;
      case (ALU_ctrl)
         3'b000: ALU_output = in0 + in1;
         3'b001: ALU_output = in0 - in1;
         3'b010: ALU_output = in0 & in1;
         3'b011: ALU_output = in0 | in1;
         3'b100: ALU_output = {15'd0, $signed(in0) < $signed(in1)};
         3'b101: ALU_output = in0 * in1;
         default: ALU_output = 16'h0000;
      endcase
      zero = (in0 == in1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [2:0] f,
                        input logic [15:0] a, input logic [15:0] b);
      bus.req_valid = 1'b1;
      bus.req_aluop = op;
      bus.req_funct = f;
      bus.req_a     = a;
      bus.req_b     = b;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_zero, bus.rsp_data, ALU_ctrl, in0, in1} !== 54'd0) begin
         failures++;
         $display("FAIL reset_init got=%h exp=0", {bus.rsp_valid, bus.rsp_data, ALU_ctrl, in0, in1});
      end
      step();
      rst_n = 1'b1;
      step();
      drive(2'b10, 3'b101, 16'h0009, 16'h0009);
      step();
      bus.req_valid = 1'b0;
      checks++;
      if (in0 !== 16'h0009) begin
         failures++;
         $display("FAIL reset_pre_exec in0 got=%h exp=0009", in0);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_zero, bus.rsp_data, ALU_ctrl, in0, in1} !== 54'd0) begin
         failures++;
         $display("FAIL reset_mid_exec got=%h exp=0", {bus.rsp_valid, bus.rsp_data, ALU_ctrl, in0, in1});
      end
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release cyc%0d valid=%b ready=%b exp valid=0 ready=1", i, bus.rsp_valid, bus.req_ready);
         end
      end
   endtask

   task automatic test_add();
      bus.rsp_ready = 1'b1;
      drive(2'b00, 3'b000, 16'h0003, 16'h0004);
      step();
      bus.req_valid = 1'b0;
      checks++;
      if (ALU_ctrl !== 3'b000 || in0 !== 16'h0003 || in1 !== 16'h0004 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL add_exec ctrl=%b in0=%h in1=%h v=%b exp 000/0003/0004/0", ALU_ctrl, in0, in1, bus.rsp_valid);
      end
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h0007 || bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL add_rsp v=%b d=%h z=%b e=%b exp 1/0007/0/0", bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_err);
      end
      step();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL add_done v=%b r=%b exp 0/1", bus.rsp_valid, bus.req_ready);
      end
   endtask

   task automatic test_sub_beq();
      drive(2'b01, 3'b000, 16'h1234, 16'h1234);
      step();
      bus.req_valid = 1'b0;
      checks++;
      if (ALU_ctrl !== 3'b001) begin
         failures++;
         $display("FAIL sub_ctrl got=%b exp=001", ALU_ctrl);
      end
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h0000 || bus.rsp_zero !== 1'b1) begin
         failures++;
         $display("FAIL sub_rsp v=%b d=%h z=%b exp 1/0000/1", bus.rsp_valid, bus.rsp_data, bus.rsp_zero);
      end
      step();
   endtask

   task automatic test_mul();
      drive(2'b10, 3'b101, 16'h0006, 16'h0007);
      step();
      bus.req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (ALU_ctrl !== 3'b101 || in0 !== 16'h0006 || in1 !== 16'h0007 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mul_hold cyc%0d ctrl=%b in0=%h in1=%h v=%b exp 101/0006/0007/0", i, ALU_ctrl, in0, in1, bus.rsp_valid);
         end
         if (i == 0) step();
      end
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h002A || bus.rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL mul_rsp v=%b d=%h e=%b exp 1/002a/0", bus.rsp_valid, bus.rsp_data, bus.rsp_err);
      end
      step();
   endtask

   task automatic test_back_to_back();
      bus.rsp_ready = 1'b0;
      drive(2'b00, 3'b000, 16'h0010, 16'h0020);
      step();
      drive(2'b00, 3'b000, 16'hFFFF, 16'hFFFF);
      step();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h0030 || bus.req_ready !== 1'b0 || in0 !== 16'h0010) begin
            failures++;
            $display("FAIL bp_stall cyc%0d v=%b d=%h r=%b in0=%h exp 1/0030/0/0010", i, bus.rsp_valid, bus.rsp_data, bus.req_ready, in0);
         end
         step();
      end
      bus.rsp_ready = 1'b1;
      drive(2'b11, 3'b000, 16'h00F0, 16'h000F);
      step();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release v=%b r=%b exp 0/1", bus.rsp_valid, bus.req_ready);
      end
      step();
      bus.req_valid = 1'b0;
      checks++;
      if (ALU_ctrl !== 3'b011 || in0 !== 16'h00F0) begin
         failures++;
         $display("FAIL bp_next_accept ctrl=%b in0=%h exp 011/00f0", ALU_ctrl, in0);
      end
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h00FF) begin
         failures++;
         $display("FAIL bp_next_rsp v=%b d=%h exp 1/00ff", bus.rsp_valid, bus.rsp_data);
      end
      step();
   endtask

   task automatic test_illegal();
      drive(2'b10, 3'b111, 16'h5555, 16'hAAAA);
      step();
      bus.req_valid = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 16'h0000 || bus.rsp_zero !== 1'b0) begin
         failures++;
         $display("FAIL ill111_rsp v=%b e=%b d=%h z=%b exp 1/1/0000/0", bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_zero);
      end
      checks++;
      if (ALU_ctrl !== 3'b011 || in0 !== 16'h00F0 || in1 !== 16'h000F) begin
         failures++;
         $display("FAIL ill111_hold ctrl=%b in0=%h in1=%h exp 011/00f0/000f", ALU_ctrl, in0, in1);
      end
      step();
      drive(2'b10, 3'b100, 16'h0001, 16'h0002);
      step();
      bus.req_valid = 1'b0;
`ifdef ALU_SLT_EN
      checks++;
      if (ALU_ctrl !== 3'b100 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL slt_exec ctrl=%b v=%b exp 100/0", ALU_ctrl, bus.rsp_valid);
      end
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 16'h0001) begin
         failures++;
         $display("FAIL slt_rsp v=%b e=%b d=%h exp 1/0/0001", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
      end
`else
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 16'h0000 || ALU_ctrl !== 3'b011 || in0 !== 16'h00F0) begin
         failures++;
         $display("FAIL slt_illegal v=%b e=%b d=%h ctrl=%b in0=%h exp 1/1/0000/011/00f0", bus.rsp_valid, bus.rsp_err, bus.rsp_data, ALU_ctrl, in0);
      end
`endif
      step();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL ill_done v=%b r=%b exp 0/1", bus.rsp_valid, bus.req_ready);
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_aluop = 2'b00;
      bus.req_funct = 3'b000;
      bus.req_a     = 16'h0000;
      bus.req_b     = 16'h0000;
      bus.rsp_ready = 1'b1;
      test_reset();
      test_add();
      test_sub_beq();
      test_mul();
      test_back_to_back();
      test_illegal();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
